// File: rtl/canvas_cursor_ctrl.sv
// canvas_cursor_ctrl
//   Front-panel sequencer for the canvas. The four direction buttons are
//   synchronised and debounced. Each debounced press moves a cursor that is
//   clamped to the canvas edges. Every move that actually changes the cursor
//   issues one pixel write over a valid/ready handshake.
//
//   Optional build macro: AUTO_REPEAT_EN
//     When defined, a held direction repeats the move every REPEAT_CYC cycles.
//     When undefined, the repeat counter is not built at all.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   buttons[3:0]     {up, down, right, left}, async, active-high
//   rgb_sel[2:0]     paint colour {R,G,B}, async
//   brush            1 = paint with rgb_sel, 0 = erase (black), async
//   wr_valid/ready   pixel write handshake (wr_valid is registered only)
//   wr_x/wr_y        write coordinate
//   wr_color         write colour
//   cur_x/cur_y      current cursor position
//   busy             a write is outstanding
module canvas_cursor_ctrl #(
  parameter int CANVAS_W     = 32,
  parameter int CANVAS_H     = 32,
  parameter int DEBOUNCE_CYC = 16,
  parameter int REPEAT_CYC   = 4096,
  localparam int XW = $clog2(CANVAS_W),
  localparam int YW = $clog2(CANVAS_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    buttons,
  input  logic [2:0]    rgb_sel,
  input  logic          brush,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic [2:0]    wr_color,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          busy
);

  localparam int DW = $clog2(DEBOUNCE_CYC);

  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // 2-flop synchronisers
  // ---------------------------------------------------------------------------
  logic [3:0] btn_s1, btn_s2;
  logic [2:0] rgb_s1, rgb_s2;
  logic       brush_s1, brush_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      rgb_s1   <= '0;
      rgb_s2   <= '0;
      brush_s1 <= 1'b0;
      brush_s2 <= 1'b0;
    end else begin
      btn_s1   <= buttons;
      btn_s2   <= btn_s1;
      rgb_s1   <= rgb_sel;
      rgb_s2   <= rgb_s1;
      brush_s1 <= brush;
      brush_s2 <= brush_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: one counter for the whole vector. Any change of the synced
  // vector restarts the count; once it has been steady long enough the vector
  // is accepted into stable. The counter saturates, so stable keeps tracking.
  // ---------------------------------------------------------------------------
  logic [3:0]    btn_prev;
  logic [DW-1:0] db_cnt;
  logic [3:0]    stable, stable_prev;
  logic          db_same, db_done;

  assign db_same = (btn_s2 == btn_prev);
  assign db_done = (db_cnt == DW'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev    <= '0;
      db_cnt      <= '0;
      stable      <= '0;
      stable_prev <= '0;
    end else begin
      btn_prev    <= btn_s2;
      stable_prev <= stable;
      if (!db_same)
        db_cnt <= '0;
      else if (!db_done)
        db_cnt <= db_cnt + DW'(1);
      if (db_same && db_done)
        stable <= btn_s2;
    end
  end

  // Press event: any stable bit rising.
  logic press_evt, move_evt;
  assign press_evt = |(stable & ~stable_prev);

`ifdef AUTO_REPEAT_EN
  // Repeat timer: restarts on any change of stable, free-runs while a button
  // is held and fires every REPEAT_CYC cycles. It keeps running while a write
  // is outstanding, so a repeat that lands in REQ is simply lost.
  localparam int RW = $clog2(REPEAT_CYC);
  logic [RW-1:0] rpt_cnt;
  logic          rpt_evt;

  assign rpt_evt = (|stable) && (stable == stable_prev) &&
                   (rpt_cnt == RW'(REPEAT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rpt_cnt <= '0;
    else if ((stable != stable_prev) || !(|stable) || rpt_evt)
      rpt_cnt <= '0;
    else
      rpt_cnt <= rpt_cnt + RW'(1);
  end

  assign move_evt = press_evt | rpt_evt;
`else
  assign move_evt = press_evt;
`endif

  // ---------------------------------------------------------------------------
  // Step and clamp. Opposing buttons cancel on that axis; edges give a zero
  // step rather than wrapping.
  // ---------------------------------------------------------------------------
  logic go_l, go_r, go_u, go_d, moved;
  logic [XW-1:0] nxt_x;
  logic [YW-1:0] nxt_y;

  assign go_r  = stable[1] & ~stable[0] & (cur_x != XW'(CANVAS_W - 1));
  assign go_l  = stable[0] & ~stable[1] & (cur_x != '0);
  assign go_d  = stable[2] & ~stable[3] & (cur_y != YW'(CANVAS_H - 1));
  assign go_u  = stable[3] & ~stable[2] & (cur_y != '0);
  assign moved = go_r | go_l | go_d | go_u;

  always_comb begin
    nxt_x = cur_x;
    nxt_y = cur_y;
    if (go_r) nxt_x = cur_x + XW'(1);
    if (go_l) nxt_x = cur_x - XW'(1);
    if (go_d) nxt_y = cur_y + YW'(1);
    if (go_u) nxt_y = cur_y - YW'(1);
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (move_evt && moved) begin
        load      = 1'b1;
        state_nxt = REQ;
      end
      REQ:  if (wr_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Cursor and write payload are captured together and held through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x    <= '0;
      cur_y    <= '0;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_color <= '0;
    end else if (load) begin
      cur_x    <= nxt_x;
      cur_y    <= nxt_y;
      wr_x     <= nxt_x;
      wr_y     <= nxt_y;
      wr_color <= brush_s2 ? rgb_s2 : 3'b000;
    end
  end

  // Decoded straight from the state register: no path from wr_ready.
  assign wr_valid = (state == REQ);
  assign busy     = (state == REQ);

endmodule
